// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator result path.
// Holds the BCD digit type, encoder FSM states and the double-dabble adjust constants.
// pow10 sizes the decimal range for the elaboration-time digit-count check.
package calc_pkg;

   typedef logic [3:0] bcd_digit_t;

   typedef enum logic {IDLE, CONV} enc_state_t;

   localparam bcd_digit_t BCD_ADJ_THRESH = 4'd5;
   localparam bcd_digit_t BCD_ADJ_ADD    = 4'd3;

   // Decimal range covered by n BCD digits (10**n), evaluated at elaboration.
   function automatic longint unsigned pow10(input int n);
      longint unsigned p;
      p = 64'd1;
      for (int i = 0; i < n; i++) begin
         p = p * 64'd10;
      end
      return p;
   endfunction

endpackage

// File: rtl/bcd_result_encoder_if.sv
// Request/result bundle between the add/sub result and the BCD encoder.
// The master drives start/bin_in; the slave (encoder) returns busy/done/bcd_out/neg.
// done is a one-cycle pulse; start is only honoured while busy is low.
interface bcd_result_encoder_if #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
);
   logic                  start;
   logic [WIDTH-1:0]      bin_in;
   logic                  busy;
   logic                  done;
   logic [4*DIGITS-1:0]   bcd_out;
   logic                  neg;

   modport master (output start, output bin_in,
                   input  busy,  input  done, input bcd_out, input neg);

   modport slave  (input  start, input  bin_in,
                   output busy,  output done, output bcd_out, output neg);
endinterface

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more.
// Purely combinational, zero latency.
// No handshake; applied to every scratch digit before each shift.
module bcd_digit_adj
   import calc_pkg::*;
(
   input  bcd_digit_t d,
   output bcd_digit_t q
);

   // Pre-shift correction so the following doubling carries into the next digit.
   always_comb begin
      q = (d >= BCD_ADJ_THRESH) ? (d + BCD_ADJ_ADD) : d;
   end

endmodule

// File: rtl/bcd_result_encoder.sv
// Sequential binary-to-BCD encoder (shift-add-3, one bit per clock); optional SIGNED_RESULT_EN build.
// Latency: done pulses WIDTH cycles after the edge that accepts start.
// Backpressure: start is ignored (not queued) while busy; accepted again in the done cycle.
module bcd_result_encoder
   import calc_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
)(
   input  logic                 clk,
   input  logic                 reset,
   bcd_result_encoder_if.slave  bus
);

   localparam int              CW      = $clog2(WIDTH + 1);
   localparam int              SW      = 4 * DIGITS;
   localparam logic [CW-1:0]   LAST    = CW'(WIDTH - 1);
   localparam longint unsigned MAX_BIN = (64'd1 << WIDTH) - 64'd1;

   // Reject configurations that cannot represent every input value.
   if (WIDTH < 2) begin : g_bad_width
      $error("bcd_result_encoder: WIDTH must be at least 2");
   end
   if (pow10(DIGITS) <= MAX_BIN) begin : g_bad_digits
      $error("bcd_result_encoder: DIGITS too small for WIDTH");
   end

   enc_state_t          state;
   enc_state_t          state_nxt;
   logic [CW-1:0]       cnt;
   logic [WIDTH-1:0]    shreg;
   logic [SW-1:0]       scratch;
   logic [SW-1:0]       scratch_adj;
   logic [SW+WIDTH-1:0] sh_all;
   logic [WIDTH-1:0]    mag;
   logic [SW-1:0]       bcd_q;
   logic                done_q;
   logic                accept;

   // One adjuster per scratch digit.
   for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      bcd_digit_adj u_adj (
         .d (scratch[4*g +: 4]),
         .q (scratch_adj[4*g +: 4])
      );
   end

   assign accept = (state == IDLE) && bus.start;
   assign sh_all = {scratch_adj, shreg} << 1;

   // Value loaded into the shift register on acceptance.
`ifdef SIGNED_RESULT_EN
   logic pend_sign;
   logic neg_q;

   always_comb begin
      mag = bus.bin_in[WIDTH-1] ? (WIDTH'(0) - bus.bin_in) : bus.bin_in;
   end
`else
   always_comb begin
      mag = bus.bin_in;
   end
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state: leave IDLE on start, return after the WIDTH-th shift.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start)   state_nxt = CONV;
         CONV:    if (cnt == LAST) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath: capture, adjust-and-shift, and load the visible result only at the end.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt     <= '0;
         shreg   <= '0;
         scratch <= '0;
         bcd_q   <= '0;
         done_q  <= 1'b0;
`ifdef SIGNED_RESULT_EN
         pend_sign <= 1'b0;
         neg_q     <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         if (accept) begin
            shreg   <= mag;
            scratch <= '0;
            cnt     <= '0;
`ifdef SIGNED_RESULT_EN
            pend_sign <= bus.bin_in[WIDTH-1];
`endif
         end else if (state == CONV) begin
            scratch <= sh_all[SW+WIDTH-1:WIDTH];
            shreg   <= sh_all[WIDTH-1:0];
            cnt     <= cnt + CW'(1);
            if (cnt == LAST) begin
               bcd_q  <= sh_all[SW+WIDTH-1:WIDTH];
               done_q <= 1'b1;
`ifdef SIGNED_RESULT_EN
               neg_q  <= pend_sign;
`endif
            end
         end
      end
   end

   // Outputs: busy follows the state, the rest are registered.
   always_comb begin
      bus.busy    = (state == CONV);
      bus.done    = done_q;
      bus.bcd_out = bcd_q;
`ifdef SIGNED_RESULT_EN
      bus.neg     = neg_q;
`else
      bus.neg     = 1'b0;
`endif
   end

endmodule

// File: tb/tb_bcd_result_encoder.sv
// Self-checking bench for bcd_result_encoder (WIDTH=8, DIGITS=3).
// Table of directed conversions plus hand sequences for ignore, reset and back-to-back.
// Expectations follow the SIGNED_RESULT_EN build selection.
module tb_bcd_result_encoder;

   logic clk;
   logic reset;
   int   total;
   int   bad;

   bcd_result_encoder_if #(.WIDTH(8), .DIGITS(3)) bus ();

   bcd_result_encoder #(.WIDTH(8), .DIGITS(3)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  bin;
      logic [11:0] exp_bcd;
      logic        exp_neg;
   } vec_t;

   vec_t vecs[6];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Accept one conversion, then watch it to completion.
   task automatic convert(input logic [7:0] v, input logic [11:0] exp_bcd, input logic exp_neg);
      logic [11:0] prev_bcd;
      logic        prev_neg;
      int          lat;
      logic        held_ok;
      prev_bcd   = bus.bcd_out;
      prev_neg   = bus.neg;
      bus.start  = 1'b1;
      bus.bin_in = v;
      tick();
      bus.start  = 1'b0;
      bus.bin_in = 8'h5A;
      check("busy_after_accept", 32'(bus.busy), 32'd1);
      lat     = 0;
      held_ok = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         tick();
         if (bus.done) begin
            lat = k;
            break;
         end
         if (bus.busy !== 1'b1 || bus.bcd_out !== prev_bcd || bus.neg !== prev_neg)
            held_ok = 1'b0;
      end
      check("latency", 32'(lat), 32'd8);
      check("held_during_conv", 32'(held_ok), 32'd1);
      check("bcd_out", 32'(bus.bcd_out), 32'(exp_bcd));
      check("neg", 32'(bus.neg), 32'(exp_neg));
      check("busy_at_done", 32'(bus.busy), 32'd0);
      tick();
      check("done_single_pulse", 32'(bus.done), 32'd0);
   endtask

   initial begin
      int lat;
      int seen_done;
      total      = 0;
      bad        = 0;
      reset      = 1'b1;
      bus.start  = 1'b0;
      bus.bin_in = 8'd0;

`ifdef SIGNED_RESULT_EN
      vecs[0] = '{8'h00, 12'h000, 1'b0};
      vecs[1] = '{8'hF6, 12'h010, 1'b1};
      vecs[2] = '{8'h80, 12'h128, 1'b1};
      vecs[3] = '{8'h7F, 12'h127, 1'b0};
      vecs[4] = '{8'hFF, 12'h001, 1'b1};
      vecs[5] = '{8'd42, 12'h042, 1'b0};
`else
      vecs[0] = '{8'd0,   12'h000, 1'b0};
      vecs[1] = '{8'd255, 12'h255, 1'b0};
      vecs[2] = '{8'd9,   12'h009, 1'b0};
      vecs[3] = '{8'd100, 12'h100, 1'b0};
      vecs[4] = '{8'd199, 12'h199, 1'b0};
      vecs[5] = '{8'd42,  12'h042, 1'b0};
`endif

      // Reset state.
      tick();
      tick();
      reset = 1'b0;
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_bcd",  32'(bus.bcd_out), 32'd0);
      check("rst_neg",  32'(bus.neg), 32'd0);

      // Table-driven conversions.
      for (int i = 0; i < 6; i++) begin
         convert(vecs[i].bin, vecs[i].exp_bcd, vecs[i].exp_neg);
      end

      // Start held high with a different value during busy: ignored, no queueing.
      bus.start  = 1'b1;
      bus.bin_in = 8'd99;
      tick();
      bus.bin_in = 8'd7;
      lat = 0;
      for (int k = 1; k <= 20; k++) begin
         tick();
         if (bus.done) begin
            lat = k;
            break;
         end
      end
      bus.start = 1'b0;
      check("ign_latency", 32'(lat), 32'd8);
      check("ign_bcd", 32'(bus.bcd_out), 32'h099);
      seen_done = 0;
      for (int k = 0; k < 12; k++) begin
         tick();
         if (bus.done || bus.busy) seen_done++;
      end
      check("ign_no_second_conv", 32'(seen_done), 32'd0);
      check("ign_bcd_kept", 32'(bus.bcd_out), 32'h099);

      // Reset in the middle of a conversion of 200.
      bus.start  = 1'b1;
      bus.bin_in = 8'd200;
      tick();
      bus.start  = 1'b0;
      tick();
      tick();
      tick();
      check("mid_busy_before_rst", 32'(bus.busy), 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("mid_rst_busy", 32'(bus.busy), 32'd0);
      check("mid_rst_done", 32'(bus.done), 32'd0);
      check("mid_rst_bcd",  32'(bus.bcd_out), 32'd0);
      check("mid_rst_neg",  32'(bus.neg), 32'd0);
      seen_done = 0;
      for (int k = 0; k < 12; k++) begin
         tick();
         if (bus.done) seen_done++;
      end
      check("mid_rst_no_done", 32'(seen_done), 32'd0);

      // Back-to-back with start held: second value accepted in the done cycle.
      bus.start  = 1'b1;
      bus.bin_in = 8'd10;
      tick();
      bus.bin_in = 8'd128;
      lat = 0;
      for (int k = 1; k <= 20; k++) begin
         tick();
         if (bus.done) begin
            lat = k;
            break;
         end
      end
      check("b2b_first_latency", 32'(lat), 32'd8);
      check("b2b_first_bcd", 32'(bus.bcd_out), 32'h010);
      check("b2b_first_neg", 32'(bus.neg), 32'd0);
      tick();
      bus.start = 1'b0;
      check("b2b_second_accepted", 32'(bus.busy), 32'd1);
      check("b2b_done_dropped", 32'(bus.done), 32'd0);
      lat = 0;
      for (int k = 1; k <= 20; k++) begin
         tick();
         if (bus.done) begin
            lat = k;
            break;
         end
      end
      check("b2b_second_latency", 32'(lat), 32'd8);
      check("b2b_second_bcd", 32'(bus.bcd_out), 32'h128);
`ifdef SIGNED_RESULT_EN
      check("b2b_second_neg", 32'(bus.neg), 32'd1);
`else
      check("b2b_second_neg", 32'(bus.neg), 32'd0);
`endif
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
